// File: rtl/rgb2ycbcr422.sv
// -----------------------------------------------------------------------------
// rgb2ycbcr422
//
// Converts 8-bit RGB pixels into BT.601 limited-range YCbCr and packs them into
// a 4:2:2 word stream (luma plus alternating Cb/Cr). It accepts one pixel per
// clock with no backpressure.
//
// Pipeline:
//   stage 1  multiply   : nine coefficient products (3 per component)
//   stage 2  sum        : per-component sum of products plus rounding constant
//   stage 3  round/clamp: arithmetic shift, offset, clamp to legal range
//   stage 4  pair       : even/odd pairing, chroma selection, word output
// The even word of a pair is output 4 cycles after its odd pixel is accepted,
// and the odd word follows one cycle later.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   pixel present this cycle
//   in_sol     first pixel of a line (qualified by in_valid), forces even phase
//   in_r/g/b   unsigned 8-bit RGB
//   out_valid  output word valid
//   out_y      luma sample (holds its value while out_valid=0)
//   out_c      chroma sample, Cb or Cr (holds its value while out_valid=0)
//   out_is_cb  1: out_c carries Cb (even word), 0: Cr (odd word)
//   out_sol    first word of a line, qualified by out_valid
//
// Build option:
//   RGB2YCBCR_CHROMA_AVG_EN  when defined, the chroma of a pair is the rounded
//                            average of both pixels (interstitial siting);
//                            otherwise the even pixel's chroma is used as-is
//                            (co-sited) and the odd pixel's chroma is dropped.
//                            Latency is identical in both builds.
// -----------------------------------------------------------------------------
module rgb2ycbcr422 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sol,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       out_valid,
    output logic [7:0] out_y,
    output logic [7:0] out_c,
    output logic       out_is_cb,
    output logic       out_sol
);

    // Component order: 0 = Y, 1 = Cb, 2 = Cr. Coefficients are scaled by 256.
    localparam int NCOMP = 3;

    localparam logic signed [17:0] COEF_R    [NCOMP] = '{ 18'sd66,  -18'sd38,  18'sd112};
    localparam logic signed [17:0] COEF_G    [NCOMP] = '{ 18'sd129, -18'sd74, -18'sd94 };
    localparam logic signed [17:0] COEF_B    [NCOMP] = '{ 18'sd25,   18'sd112, -18'sd18 };
    localparam logic signed [17:0] OFFSET    [NCOMP] = '{ 18'sd16,   18'sd128,  18'sd128};
    localparam logic signed [17:0] CLAMP_MIN [NCOMP] = '{ 18'sd16,   18'sd16,   18'sd16 };
    localparam logic signed [17:0] CLAMP_MAX [NCOMP] = '{ 18'sd235,  18'sd240,  18'sd240};

    // -------------------------------------------------------------------------
    // Control pipeline: valid and start-of-line travel alongside the data.
    // -------------------------------------------------------------------------
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s3_valid_d, s3_valid_q;
    logic s1_sol_d,   s1_sol_q;
    logic s2_sol_d,   s2_sol_q;
    logic s3_sol_d,   s3_sol_q;

    always_comb begin
        s1_valid_d = in_valid;
        s1_sol_d   = in_valid & in_sol;
        s2_valid_d = s1_valid_q;
        s2_sol_d   = s1_sol_q;
        s3_valid_d = s2_valid_q;
        s3_sol_d   = s2_sol_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_sol_q   <= 1'b0;
            s2_sol_q   <= 1'b0;
            s3_sol_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_sol_q   <= s1_sol_d;
            s2_sol_q   <= s2_sol_d;
            s3_sol_q   <= s3_sol_d;
        end
    end

    // -------------------------------------------------------------------------
    // Conversion datapath, one slice per component.
    // All intermediates fit in 18-bit signed: the largest magnitude is
    // 220*255 + 128 = 56228 for luma.
    // -------------------------------------------------------------------------
    logic [7:0] s3_comp [NCOMP];

    genvar gi;
    generate
        for (gi = 0; gi < NCOMP; gi++) begin : g_comp
            logic signed [17:0] prod_r_d, prod_r_q;
            logic signed [17:0] prod_g_d, prod_g_q;
            logic signed [17:0] prod_b_d, prod_b_q;
            logic signed [17:0] sum_d,    sum_q;
            logic signed [17:0] scaled;
            logic        [7:0]  res_d,    res_q;

            always_comb begin
                // Stage 1: products. Pixel values are zero-extended so the
                // multiply stays signed.
                prod_r_d = COEF_R[gi] * $signed({10'd0, in_r});
                prod_g_d = COEF_G[gi] * $signed({10'd0, in_g});
                prod_b_d = COEF_B[gi] * $signed({10'd0, in_b});

                // Stage 2: sum with half-LSB rounding constant.
                sum_d = prod_r_q + prod_g_q + prod_b_q + 18'sd128;

                // Stage 3: floor-divide by 256 (arithmetic shift), add the
                // component offset, then clamp into the legal range.
                scaled = (sum_q >>> 8) + OFFSET[gi];
                if (scaled < CLAMP_MIN[gi]) begin
                    res_d = CLAMP_MIN[gi][7:0];
                end else if (scaled > CLAMP_MAX[gi]) begin
                    res_d = CLAMP_MAX[gi][7:0];
                end else begin
                    res_d = scaled[7:0];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_r_q <= '0;
                    prod_g_q <= '0;
                    prod_b_q <= '0;
                    sum_q    <= '0;
                    res_q    <= '0;
                end else begin
                    prod_r_q <= prod_r_d;
                    prod_g_q <= prod_g_d;
                    prod_b_q <= prod_b_d;
                    sum_q    <= sum_d;
                    res_q    <= res_d;
                end
            end

            assign s3_comp[gi] = res_q;
        end
    endgenerate

    logic [7:0] s3_y;
    logic [7:0] s3_cb;
    logic [7:0] s3_cr;

    assign s3_y  = s3_comp[0];
    assign s3_cb = s3_comp[1];
    assign s3_cr = s3_comp[2];

    // -------------------------------------------------------------------------
    // Pair stage.
    //   hold_*  : even pixel waiting for its odd partner
    //   pend_*  : odd word queued for the cycle after its even word
    //   odd_phase_q : next converted pixel is the odd member of a pair
    // A pending odd word can only coincide with a new even pixel, never with
    // another odd pixel or a flush, so one pending slot is sufficient.
    // -------------------------------------------------------------------------
    logic       odd_phase_d, odd_phase_q;
    logic       hold_valid_d, hold_valid_q;
    logic [7:0] hold_y_d,  hold_y_q;
    logic [7:0] hold_cb_d, hold_cb_q;
    logic [7:0] hold_cr_d, hold_cr_q;
    logic       hold_sol_d, hold_sol_q;
    logic       pend_valid_d, pend_valid_q;
    logic [7:0] pend_y_d, pend_y_q;
    logic [7:0] pend_c_d, pend_c_q;

    logic       out_valid_d, out_valid_q;
    logic [7:0] out_y_d,     out_y_q;
    logic [7:0] out_c_d,     out_c_q;
    logic       out_is_cb_d, out_is_cb_q;
    logic       out_sol_d,   out_sol_q;

    // Chroma delivered with a completed pair.
    logic [7:0] pair_cb;
    logic [7:0] pair_cr;

`ifdef RGB2YCBCR_CHROMA_AVG_EN
    // Rounded average with a 9-bit sum; the halved result always fits 8 bits.
    always_comb begin
        pair_cb = 8'(({1'b0, hold_cb_q} + {1'b0, s3_cb} + 9'd1) >> 1);
        pair_cr = 8'(({1'b0, hold_cr_q} + {1'b0, s3_cr} + 9'd1) >> 1);
    end
`else
    // Co-sited chroma: the even pixel supplies both Cb and Cr.
    always_comb begin
        pair_cb = hold_cb_q;
        pair_cr = hold_cr_q;
    end
`endif

    logic s3_is_even;
    assign s3_is_even = s3_sol_q | ~odd_phase_q;

    always_comb begin
        odd_phase_d  = odd_phase_q;
        hold_valid_d = hold_valid_q;
        hold_y_d     = hold_y_q;
        hold_cb_d    = hold_cb_q;
        hold_cr_d    = hold_cr_q;
        hold_sol_d   = hold_sol_q;
        pend_valid_d = pend_valid_q;
        pend_y_d     = pend_y_q;
        pend_c_d     = pend_c_q;
        out_valid_d  = 1'b0;
        out_y_d      = out_y_q;
        out_c_d      = out_c_q;
        out_is_cb_d  = 1'b0;
        out_sol_d    = 1'b0;

        if (s3_valid_q && s3_is_even) begin
            if (hold_valid_q) begin
                // Line ended with an unpaired even pixel: flush it alone
                // with its own Cb and keep its start-of-line marker.
                out_valid_d = 1'b1;
                out_y_d     = hold_y_q;
                out_c_d     = hold_cb_q;
                out_is_cb_d = 1'b1;
                out_sol_d   = hold_sol_q;
            end else if (pend_valid_q) begin
                out_valid_d  = 1'b1;
                out_y_d      = pend_y_q;
                out_c_d      = pend_c_q;
                pend_valid_d = 1'b0;
            end
            hold_valid_d = 1'b1;
            hold_y_d     = s3_y;
            hold_cb_d    = s3_cb;
            hold_cr_d    = s3_cr;
            hold_sol_d   = s3_sol_q;
            odd_phase_d  = 1'b1;
        end else if (s3_valid_q) begin
            // Odd partner arrived: emit the even word now, queue the odd word.
            out_valid_d  = 1'b1;
            out_y_d      = hold_y_q;
            out_c_d      = pair_cb;
            out_is_cb_d  = 1'b1;
            out_sol_d    = hold_sol_q;
            pend_valid_d = 1'b1;
            pend_y_d     = s3_y;
            pend_c_d     = pair_cr;
            hold_valid_d = 1'b0;
            odd_phase_d  = 1'b0;
        end else if (pend_valid_q) begin
            out_valid_d  = 1'b1;
            out_y_d      = pend_y_q;
            out_c_d      = pend_c_q;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd_phase_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_y_q     <= '0;
            hold_cb_q    <= '0;
            hold_cr_q    <= '0;
            hold_sol_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_y_q     <= '0;
            pend_c_q     <= '0;
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_c_q      <= '0;
            out_is_cb_q  <= 1'b0;
            out_sol_q    <= 1'b0;
        end else begin
            odd_phase_q  <= odd_phase_d;
            hold_valid_q <= hold_valid_d;
            hold_y_q     <= hold_y_d;
            hold_cb_q    <= hold_cb_d;
            hold_cr_q    <= hold_cr_d;
            hold_sol_q   <= hold_sol_d;
            pend_valid_q <= pend_valid_d;
            pend_y_q     <= pend_y_d;
            pend_c_q     <= pend_c_d;
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_c_q      <= out_c_d;
            out_is_cb_q  <= out_is_cb_d;
            out_sol_q    <= out_sol_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_c     = out_c_q;
    assign out_is_cb = out_is_cb_q;
    assign out_sol   = out_sol_q;

endmodule

// File: tb/tb_rgb2ycbcr422.sv
// -----------------------------------------------------------------------------
// tb_rgb2ycbcr422
//
// Directed and random stimulus for rgb2ycbcr422. A reference model converts
// each accepted pixel with the BT.601 integer formulas, applies the pairing
// rules and schedules every expected word at its absolute output cycle. A
// single compare process checks the DUT against that schedule every cycle.
// Literal expectations pin the conversion formulas and the directed cases.
// -----------------------------------------------------------------------------
module tb_rgb2ycbcr422;

`ifdef RGB2YCBCR_CHROMA_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sol = 1'b0;
    logic [7:0] in_r = '0;
    logic [7:0] in_g = '0;
    logic [7:0] in_b = '0;
    logic       out_valid;
    logic [7:0] out_y;
    logic [7:0] out_c;
    logic       out_is_cb;
    logic       out_sol;

    rgb2ycbcr422 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sol    (in_sol),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_y     (out_y),
        .out_c     (out_c),
        .out_is_cb (out_is_cb),
        .out_sol   (out_sol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int y;
        int c;
        bit is_cb;
        bit sol;
    } word_t;

    word_t exp_q[$];
    word_t seen_q[$];
    word_t cmp_e;
    int    tests_run = 0;
    int    tests_failed = 0;
    int    push_count = 0;

    // Model state
    bit m_odd = 1'b0;
    bit m_hold_v = 1'b0;
    int m_y, m_cb, m_cr;
    bit m_sol;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void conv(input int r, input int g, input int b,
                                 output int y, output int cb, output int cr);
        y  = clampi(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16, 16, 235);
        cb = clampi(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128, 16, 240);
        cr = clampi(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128, 16, 240);
    endfunction

    function automatic void push(input int t, input int y, input int c,
                                 input bit is_cb, input bit sol);
        word_t w;
        w.t = t; w.y = y; w.c = c; w.is_cb = is_cb; w.sol = sol;
        exp_q.push_back(w);
        push_count++;
    endfunction

    // Pixel accepted while the bench cycle counter reads t.
    function automatic void model_accept(input int t, input bit sol,
                                         input int r, input int g, input int b);
        int y, cb, cr, cbo, cro;
        conv(r, g, b, y, cb, cr);
        if (sol || !m_odd) begin
            if (m_hold_v) push(t + 4, m_y, m_cb, 1'b1, m_sol);
            m_hold_v = 1'b1;
            m_y = y; m_cb = cb; m_cr = cr; m_sol = sol;
            m_odd = 1'b1;
        end else begin
            cbo = AVG ? (m_cb + cb + 1) / 2 : m_cb;
            cro = AVG ? (m_cr + cr + 1) / 2 : m_cr;
            push(t + 4, m_y, cbo, 1'b1, m_sol);
            push(t + 5, y, cro, 1'b0, 1'b0);
            m_hold_v = 1'b0;
            m_odd = 1'b0;
        end
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    task automatic check_seen(input string name, input int idx, input int y,
                              input int c, input bit is_cb, input bit sol);
        tests_run++;
        if (idx >= seen_q.size()) begin
            tests_failed++;
            $display("FAIL %s: word %0d missing, expected y=%0d c=%0d cb=%0d sol=%0d",
                     name, idx, y, c, is_cb, sol);
        end else if (seen_q[idx].y != y || seen_q[idx].c != c ||
                     seen_q[idx].is_cb != is_cb || seen_q[idx].sol != sol) begin
            tests_failed++;
            $display("FAIL %s: got y=%0d c=%0d cb=%0d sol=%0d, expected y=%0d c=%0d cb=%0d sol=%0d",
                     name, seen_q[idx].y, seen_q[idx].c, seen_q[idx].is_cb, seen_q[idx].sol,
                     y, c, is_cb, sol);
        end else begin
            $display("[TB] ok %s y=%0d c=%0d cb=%0d sol=%0d", name, y, c, is_cb, sol);
        end
    endtask

    // Compare process: every cycle either the scheduled word or silence.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                cmp_e.t = cyc; cmp_e.y = out_y; cmp_e.c = out_c;
                cmp_e.is_cb = out_is_cb; cmp_e.sol = out_sol;
                seen_q.push_back(cmp_e);
            end
            if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
                cmp_e = exp_q.pop_front();
                tests_run++;
                if (!out_valid || exp_q.size() < 0 || cmp_e.t != cyc ||
                    out_y != cmp_e.y[7:0] || out_c != cmp_e.c[7:0] ||
                    out_is_cb != cmp_e.is_cb || out_sol != cmp_e.sol) begin
                    tests_failed++;
                    $display("FAIL word cyc=%0d: got v=%0d y=%0d c=%0d cb=%0d sol=%0d, expected at cyc=%0d y=%0d c=%0d cb=%0d sol=%0d",
                             cyc, out_valid, out_y, out_c, out_is_cb, out_sol,
                             cmp_e.t, cmp_e.y, cmp_e.c, cmp_e.is_cb, cmp_e.sol);
                end
            end else begin
                tests_run++;
                if (out_valid) begin
                    tests_failed++;
                    $display("FAIL idle cyc=%0d: got unexpected word y=%0d c=%0d cb=%0d, expected out_valid=0",
                             cyc, out_y, out_c, out_is_cb);
                end
            end
        end
    end

    task automatic drive(input bit v, input bit sol, input int r, input int g, input int b);
        in_valid = v;
        in_sol   = sol;
        in_r     = 8'(r);
        in_g     = 8'(g);
        in_b     = 8'(b);
        if (v) begin
            model_accept(cyc, sol, r, g, b);
            $display("[TB] cyc=%0d pixel sol=%0d rgb=(%0d,%0d,%0d)", cyc, sol, r, g, b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        repeat (8) drive(1'b0, 1'b0, 0, 0, 0);
        check_int({name, " drained"}, exp_q.size(), 0);
    endtask

    int y0, cb0, cr0;
    int idx;
    int pc0;

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check_int("reset out_valid", int'(out_valid), 0);
        check_int("reset out_y", int'(out_y), 0);
        check_int("reset out_c", int'(out_c), 0);
        check_int("reset out_is_cb", int'(out_is_cb), 0);
        check_int("reset out_sol", int'(out_sol), 0);

        // Pin the conversion formulas with hand-computed values
        conv(255, 255, 255, y0, cb0, cr0);
        check_int("pin white y", y0, 235);
        check_int("pin white cb", cb0, 128);
        conv(0, 0, 0, y0, cb0, cr0);
        check_int("pin black y", y0, 16);
        check_int("pin black cr", cr0, 128);
        conv(255, 0, 0, y0, cb0, cr0);
        check_int("pin red y", y0, 82);
        check_int("pin red cb", cb0, 90);
        check_int("pin red cr", cr0, 240);
        conv(0, 0, 255, y0, cb0, cr0);
        check_int("pin blue y", y0, 41);
        check_int("pin blue cb", cb0, 240);
        check_int("pin blue cr", cr0, 110);

        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // White pair
        idx = seen_q.size();
        drive(1'b1, 1'b1, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        drain("white");
        check_seen("white even", idx, 235, 128, 1'b1, 1'b1);
        check_seen("white odd", idx + 1, 235, 128, 1'b0, 1'b0);

        // Black pair
        idx = seen_q.size();
        drive(1'b1, 1'b1, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0);
        drain("black");
        check_seen("black even", idx, 16, 128, 1'b1, 1'b1);
        check_seen("black odd", idx + 1, 16, 128, 1'b0, 1'b0);

        // Red even + blue odd
        idx = seen_q.size();
        drive(1'b1, 1'b1, 255, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 255);
        drain("red-blue");
        check_seen("red-blue even", idx, 82, AVG ? 165 : 90, 1'b1, 1'b1);
        check_seen("red-blue odd", idx + 1, 41, AVG ? 175 : 240, 1'b0, 1'b0);

        // Gap between even and odd pixel
        idx = seen_q.size();
        drive(1'b1, 1'b1, 255, 255, 255);
        repeat (5) drive(1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0);
        drain("gap");
        check_seen("gap even", idx, 235, 128, 1'b1, 1'b1);
        check_seen("gap odd", idx + 1, 16, 128, 1'b0, 1'b0);

        // Line of 3 then a new line: black flushed alone
        idx = seen_q.size();
        drive(1'b1, 1'b1, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        drive(1'b1, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 255, 0, 0);
        drain("line3");
        check_seen("line3 w0", idx, 235, 128, 1'b1, 1'b1);
        check_seen("line3 w1", idx + 1, 235, 128, 1'b0, 1'b0);
        check_seen("line3 flush", idx + 2, 16, 128, 1'b1, 1'b0);
        check_int("line3 word count", seen_q.size() - idx, 3);

        // 1024 back-to-back random pixels (red above still pending)
        idx = seen_q.size();
        pc0 = push_count;
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, (i == 0) || ($urandom_range(0, 31) == 0),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
        end
        drain("random");
        check_int("random word count", seen_q.size() - idx, push_count - pc0);

        // Reset with pixels in flight
        drive(1'b1, 1'b1, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        drive(1'b1, 1'b0, 255, 255, 255);
        in_valid = 1'b0;
        check_int("pre-reset out_valid", int'(out_valid), 1);
        check_int("pre-reset out_y", int'(out_y), 235);
        #2 rst = 1'b1;
        exp_q.delete();
        m_odd = 1'b0;
        m_hold_v = 1'b0;
        #1;
        check_int("mid reset out_valid", int'(out_valid), 0);
        check_int("mid reset out_y", int'(out_y), 0);
        check_int("mid reset out_c", int'(out_c), 0);
        check_int("mid reset out_is_cb", int'(out_is_cb), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        idx = seen_q.size();
        repeat (8) drive(1'b0, 1'b0, 0, 0, 0);
        check_int("no stale words", seen_q.size() - idx, 0);
        drive(1'b1, 1'b0, 255, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 255);
        drain("post-reset");
        check_seen("post-reset even", idx, 82, AVG ? 165 : 90, 1'b1, 1'b0);
        check_seen("post-reset odd", idx + 1, 41, AVG ? 175 : 240, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rgb2ycbcr422.md
# rgb2ycbcr422

Converts 8-bit-per-channel RGB pixels to BT.601 limited-range YCbCr and packs them into a 16-bit 4:2:2 stream (Y plus alternating Cb/Cr). It is the encoding counterpart of the YCbCr-to-RGB path: it sits between the RGB pixel source (test-pattern or frame-buffer reader) and the BT.656/4:2:2 output formatter. It is fully pipelined and accepts one pixel per clock.

## Interface
- Parameters: none; coefficients and clamp limits are fixed (BT.601, limited range).
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present this cycle; may be any pattern, no backpressure
- in_sol  in  1  qualified by in_valid; first pixel of a line; forces even phase
- in_r, in_g, in_b  in  8 each  unsigned RGB
- out_valid  out  1  output word valid
- out_y  out  8  luma
- out_c  out  8  chroma sample (Cb or Cr)
- out_is_cb  out  1  1: out_c is Cb (even word), 0: Cr (odd word)
- out_sol  out  1  first word of a line, qualified by out_valid

## Operation
- Conversion, signed 18-bit intermediates, coefficients ×256:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - Cb = ((−38R − 74G + 112B + 128) >>> 8) + 128
  - Cr = ((112R − 94G − 18B + 128) >>> 8) + 128
- `>>>` is an arithmetic shift, which floors the result. Clamp Y to 16..235 and Cb/Cr to 16..240.
- Pair phase: toggles on every valid pixel. in_sol with in_valid forces the pixel to even, then the next pixel is odd.
- An even pixel is held (Y0, Cb0, Cr0) until its odd partner arrives. The pair then emits two consecutive words:
  - even word: {Y0, Cb}, out_is_cb=1
  - odd word: {Y1, Cr}, out_is_cb=0
  - Cb/Cr come from the averaging rule in Configuration.
- out_sol=1 on the even word of the first pair of a line.
- Dangling even pixel: a pending even pixel whose line ends (next valid pixel has in_sol=1) is flushed alone as an even word with its own Cb. No odd word follows it. Its out_sol is kept.
- Gaps in in_valid between an even and odd pixel are allowed; the hold register keeps the even pixel indefinitely.

## Timing
- Conversion pipeline is 3 stages: multiply, sum, round/clamp. The pair stage adds 1 more.
- Odd pixel accepted at cycle t: even word has out_valid at t+4 and odd word at t+5.
- Flush: new in_sol pixel accepted at t → flushed even word at t+4.
- Back-to-back input never collides: successive pairs are ≥2 cycles apart, and an even pixel produces no output in its own cycle.
- Reset (async, any time): clears the pipeline, hold register and phase to even; in-flight pixels are discarded.
- Reset values of all outputs: out_valid, out_y, out_c, out_is_cb and out_sol are 0.
- First valid pixel after reset is treated as even even without in_sol.
- out_y and out_c hold their last values when out_valid=0.

## Configuration
- `RGB2YCBCR_CHROMA_AVG_EN` defined: Cb = (Cb0 + Cb1 + 1) >> 1 and Cr = (Cr0 + Cr1 + 1) >> 1, using a 9-bit sum. This is interstitial chroma siting.
- Not defined: Cb = Cb0 and Cr = Cr0, taken from the even pixel. This is co-sited chroma, and the odd pixel's chroma is discarded.
- Latency and timing are identical in both builds.

## Test plan
- White pair (255,255,255)×2 → words {235,128,cb=1}, {235,128,cb=0} at t+4 and t+5.
- Black pair (0,0,0)×2 → {16,128}, {16,128}.
- Red (255,0,0) even + blue (0,0,255) odd, with in_sol on red:
  - with macro → {82,165,sol=1}, {41,175}
  - without macro → {82,90,sol=1}, {41,240}
- Line of 3 pixels (white, white, black), then in_sol pixel → words {235,128}, {235,128}, then black flushed as {16,128,cb=1} 4 cycles after the in_sol pixel; no Cr word follows it.
- in_valid every cycle for 1024 random pixels vs. a reference model → word count, order and phase match exactly, with no gaps in pair output.
- Assert rst while 3 pixels are in flight → outputs 0 immediately, no stale words after release; next pixel is treated as even.
